// File: rtl/baud_nco_generator_pkg.sv
// ---------------------------------------------------------------------------
// baud_nco_generator_pkg
//   Shared constants for the NCO baud generator: the baud-rate table, the
//   mode encoding and the elaboration-time increment calculator.
//   No ports (package).
// ---------------------------------------------------------------------------
package baud_nco_generator_pkg;

    localparam int SEL_W   = 3;
    localparam int N_RATES = 8;

    typedef enum logic {
        TYPE_TX = 1'b0,
        TYPE_RX = 1'b1
    } baud_type_e;

    // Index 0 is the rightmost entry: baud_select 000 -> 300 Bd.
    localparam logic [N_RATES-1:0][31:0] RATE_TABLE = {
        32'd115200, 32'd57600, 32'd38400, 32'd19200,
        32'd9600,   32'd4800,  32'd1200,  32'd300
    };

    // round(rate * mult * 2^acc_w / clk_hz) in integer arithmetic; only ever
    // evaluated on constants, so it folds away at elaboration.
    function automatic longint unsigned calc_inc(
        input longint unsigned rate,
        input longint unsigned mult,
        input longint unsigned clk_hz,
        input int unsigned     acc_w
    );
        longint unsigned num;
        num = (rate * mult) << acc_w;
        return (num + clk_hz / 2) / clk_hz;
    endfunction

endpackage

// File: rtl/baud_nco_generator_nco.sv
// ---------------------------------------------------------------------------
// baud_nco
//   Phase accumulator with carry-out. Each enabled cycle the accumulator
//   advances by inc_i modulo 2^ACC_W; carry_o flags the cycle whose add
//   overflows, and is suppressed whenever the accumulator is being cleared
//   or reloaded.
// Ports
//   clk_i        system clock, rising edge
//   reset_ni     asynchronous reset, active low
//   en_i         1 = accumulate this cycle, 0 = hold
//   clr_i        force accumulator to 0 (highest priority)
//   load_half_i  force accumulator to 2^(ACC_W-1)
//   inc_i        phase increment
//   carry_o      overflow of the add performed this cycle (combinational)
// ---------------------------------------------------------------------------
module baud_nco #(
    parameter int ACC_W = 24
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             load_half_i,
    input  logic [ACC_W-1:0] inc_i,
    output logic             carry_o
);

    localparam logic [ACC_W-1:0] HALF = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W:0]   sum;

    assign sum = {1'b0, acc_q} + {1'b0, inc_i};

    always_comb begin
        // NOTE: default first so every path assigns acc_d -- no latch.
        acc_d = acc_q;
        if (clr_i)            acc_d = '0;
        else if (load_half_i) acc_d = HALF;
        else if (en_i)        acc_d = sum[ACC_W-1:0];
    end

    assign carry_o = en_i && !clr_i && !load_half_i && sum[ACC_W];

    // NOTE: state registers use non-blocking assignment and the async reset
    // in the sensitivity list, so reset takes effect without a clock edge.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) acc_q <= '0;
        else           acc_q <= acc_d;
    end

endmodule

// File: rtl/baud_nco_generator.sv
// ---------------------------------------------------------------------------
// baud_nco_generator
//   Fractional (NCO) baud tick source for the UART. RX mode gives OVERSAMPLE
//   sample ticks per bit plus a bit tick; TX mode gives one tick per bit.
//   Supports a runtime custom increment, RX phase resync on the start-bit
//   edge and glitch-free rate changes.
// Ports
//   clk_i            system clock, rising edge
//   reset_ni         asynchronous reset, active low
//   enable_i         1 = run, 0 = freeze phase and suppress ticks
//   type_i           1 = RX (oversampled), 0 = TX (bit rate)
//   baud_select_i    rate index 0..7 = 300 .. 115200 Bd
//   custom_en_i      1 = use custom_inc_i instead of the table
//   custom_inc_i     accumulator increment when custom_en_i = 1
//   resync_i         RX only: 1-cycle pulse restarting the bit phase
//   sample_enable_o  1-cycle tick per sample (RX) or per bit (TX)
//   bit_tick_o       1-cycle tick once per bit period
//   cfg_busy_o       high for the one cycle in which a config change lands
// ---------------------------------------------------------------------------
module baud_nco_generator
    import baud_nco_generator_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int OVERSAMPLE = 16,
    parameter int ACC_W      = 24
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             enable_i,
    input  logic             type_i,
    input  logic [SEL_W-1:0] baud_select_i,
    input  logic             custom_en_i,
    input  logic [ACC_W-1:0] custom_inc_i,
    input  logic             resync_i,
    output logic             sample_enable_o,
    output logic             bit_tick_o,
    output logic             cfg_busy_o
);

    localparam int SUB_W = $clog2(OVERSAMPLE);
    localparam int CFG_W = 1 + SEL_W + 1 + ACC_W;

    typedef logic [1:0][N_RATES-1:0][ACC_W-1:0] inc_table_t;

    function automatic inc_table_t build_table();
        inc_table_t tbl;
        tbl = '0;
        for (int t = 0; t < 2; t++) begin
            for (int s = 0; s < N_RATES; s++) begin
                tbl[t][s] = ACC_W'(calc_inc(
                    64'(RATE_TABLE[s]),
                    (t == 1) ? 64'(OVERSAMPLE) : 64'd1,
                    64'(CLK_HZ),
                    ACC_W));
            end
        end
        return tbl;
    endfunction

    // Indexed [type][baud_select]; constant after elaboration.
    localparam inc_table_t INC_TABLE = build_table();

    logic [ACC_W-1:0] inc;
    logic [CFG_W-1:0] cfg_now, cfg_q;
    logic             cfg_valid_q;
    logic             cfg_change;
    logic             is_rx;
    logic             do_resync;
    logic             carry;

    logic [SUB_W-1:0] sub_q, sub_d;
    logic             sample_q, sample_d;
    logic             bit_q, bit_d;
    logic             busy_q, busy_d;

    assign is_rx = (baud_type_e'(type_i) == TYPE_RX);
    assign inc   = custom_en_i ? custom_inc_i : INC_TABLE[type_i][baud_select_i];

    // custom_inc only counts as configuration while it is selected.
    assign cfg_now = {type_i, baud_select_i, custom_en_i,
                      custom_inc_i & {ACC_W{custom_en_i}}};

    // cfg_valid_q blocks a spurious change on the first cycle after reset,
    // before cfg_q has captured the live configuration.
    assign cfg_change = cfg_valid_q && (cfg_now != cfg_q);
    assign do_resync  = !cfg_change && resync_i && enable_i && is_rx;

    baud_nco #(
        .ACC_W (ACC_W)
    ) u_nco (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .en_i        (enable_i),
        .clr_i       (cfg_change),
        .load_half_i (do_resync),
        .inc_i       (inc),
        .carry_o     (carry)
    );

    always_comb begin
        sub_d    = sub_q;
        sample_d = 1'b0;
        bit_d    = 1'b0;
        busy_d   = 1'b0;
        if (cfg_change) begin
            sub_d  = '0;
            busy_d = 1'b1;
        end else if (do_resync) begin
            sub_d = '0;
        end else if (carry) begin
            sample_d = 1'b1;
            if (is_rx) begin
                sub_d = sub_q + 1'b1;
                bit_d = (sub_q == SUB_W'(OVERSAMPLE - 1));
            end else begin
                sub_d = '0;
                bit_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cfg_q       <= '0;
            cfg_valid_q <= 1'b0;
            sub_q       <= '0;
            sample_q    <= 1'b0;
            bit_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            cfg_q       <= cfg_now;
            cfg_valid_q <= 1'b1;
            sub_q       <= sub_d;
            sample_q    <= sample_d;
            bit_q       <= bit_d;
            busy_q      <= busy_d;
        end
    end

    assign sample_enable_o = sample_q;
    assign bit_tick_o      = bit_q;
    assign cfg_busy_o      = busy_q;

endmodule

// File: tb/tb_baud_nco_generator.sv
// ---------------------------------------------------------------------------
// tb_baud_nco_generator
//   Directed bench for baud_nco_generator at CLK_HZ=100e6, ACC_W=24,
//   OVERSAMPLE=16. Expected tick positions follow from the table increments:
//     RX 115200 inc 309238, RX 57600 inc 154619, TX 9600 inc 1611,
//     TX 115200 inc 19327.
//   Starting from acc=0, tick n lands ceil(n*2^24/inc) edges after the edge
//   that cleared the accumulator.
// ---------------------------------------------------------------------------
module tb_baud_nco_generator;

    logic        clk = 1'b0;
    logic        reset_ni = 1'b1;
    logic        enable_i = 1'b1;
    logic        type_i = 1'b1;
    logic [2:0]  baud_select_i = 3'd7;
    logic        custom_en_i = 1'b0;
    logic [23:0] custom_inc_i = '0;
    logic        resync_i = 1'b0;
    logic        sample_enable_o;
    logic        bit_tick_o;
    logic        cfg_busy_o;

    int checks = 0;
    int errors = 0;
    int stray  = 0;   // bit ticks seen without a sample tick
    logic last_bit;   // bit_tick value at the last detected sample tick

    baud_nco_generator #(
        .CLK_HZ     (100_000_000),
        .OVERSAMPLE (16),
        .ACC_W      (24)
    ) dut (
        .clk_i           (clk),
        .reset_ni        (reset_ni),
        .enable_i        (enable_i),
        .type_i          (type_i),
        .baud_select_i   (baud_select_i),
        .custom_en_i     (custom_en_i),
        .custom_inc_i    (custom_inc_i),
        .resync_i        (resync_i),
        .sample_enable_o (sample_enable_o),
        .bit_tick_o      (bit_tick_o),
        .cfg_busy_o      (cfg_busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n edges, sampling #1 after each; counts ticks seen.
    task automatic step(input int n, output int samples, output int bits);
        samples = 0;
        bits    = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (sample_enable_o) samples++;
            if (bit_tick_o) bits++;
            if (bit_tick_o && !sample_enable_o) stray++;
        end
    endtask

    // Edges until the next sample tick; -1 if none within limit.
    task automatic wait_tick(input int limit, output int edges);
        edges = -1;
        for (int n = 1; n <= limit; n++) begin
            @(posedge clk);
            #1;
            if (bit_tick_o && !sample_enable_o) stray++;
            if (sample_enable_o) begin
                edges    = n;
                last_bit = bit_tick_o;
                break;
            end
        end
    endtask

    initial begin
        int e, s, b, span, bits, bad, pos;

        // ---- reset state ----
        #2 reset_ni = 1'b0;
        #1;
        check("rst_sample", sample_enable_o, 0);
        check("rst_bit", bit_tick_o, 0);
        check("rst_busy", cfg_busy_o, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) reset_ni = 1'b1;

        // ---- RX 115200: first tick ceil(2^24/309238)=55 ----
        wait_tick(200, e);
        check("rx_first_tick", e, 55);
        // ticks 2..161: tick 161 at edge 8735, so span 8680, periods 54/55,
        // bit ticks at samples 16..160
        span = 0; bits = 0; bad = 0;
        for (int i = 0; i < 160; i++) begin
            wait_tick(200, e);
            span += e;
            if (e != 54 && e != 55) bad++;
            if (last_bit) bits++;
        end
        check("rx_span_160", span, 8680);
        check("rx_period_jitter", bad, 0);
        check("rx_bit_count", bits, 10);
        check("rx_stray_bits", stray, 0);

        // ---- TX 9600: config change, first tick ceil(2^24/1611)=10415 ----
        type_i = 1'b0; baud_select_i = 3'd3;
        step(1, s, b);
        check("tx3_busy", cfg_busy_o, 1);
        check("tx3_busy_no_tick", sample_enable_o, 0);
        wait_tick(11000, e);
        check("tx3_first_tick", e, 10415);
        check("tx3_bit_eq_sample", last_bit, 1);

        // ---- TX 115200: first tick 869, tick 11 at 9549 -> span 8680 ----
        baud_select_i = 3'd7;
        step(1, s, b);
        check("tx7_busy", cfg_busy_o, 1);
        wait_tick(1000, e);
        check("tx7_first_tick", e, 869);
        span = 0; bits = 0;
        for (int i = 0; i < 10; i++) begin
            wait_tick(1000, e);
            span += e;
            if (last_bit) bits++;
        end
        check("tx7_span_10", span, 8680);
        check("tx7_bit_count", bits, 10);
        // resync ignored in TX: tick 12 still at edge 10417, 867 after pulse
        resync_i = 1'b1;
        step(1, s, b);
        resync_i = 1'b0;
        wait_tick(1000, e);
        check("tx_resync_ignored", e, 867);

        // ---- custom 2^23: tick every 2nd clk ----
        custom_en_i = 1'b1; custom_inc_i = 24'h800000;
        step(1, s, b);
        check("cust_busy", cfg_busy_o, 1);
        wait_tick(10, e);
        check("cust_half_first", e, 2);
        span = 0;
        for (int i = 0; i < 5; i++) begin
            wait_tick(10, e);
            span += e;
        end
        check("cust_half_span5", span, 10);

        // ---- custom max: ticks at edge 2, then every edge ----
        custom_inc_i = 24'hFFFFFF;
        step(1, s, b);
        check("cust_max_busy", cfg_busy_o, 1);
        wait_tick(10, e);
        check("cust_max_first", e, 2);
        wait_tick(10, e);
        check("cust_max_second", e, 1);

        // ---- custom 0: no ticks in 10000 clk ----
        custom_inc_i = 24'h000000;
        step(1, s, b);
        check("cust_zero_busy", cfg_busy_o, 1);
        step(10000, s, b);
        check("cust_zero_ticks", s, 0);

        // ---- enable freeze: back to RX 115200 ----
        custom_en_i = 1'b0; type_i = 1'b1; baud_select_i = 3'd7;
        step(1, s, b);
        check("en_busy", cfg_busy_o, 1);
        wait_tick(200, e);
        check("en_first_tick", e, 55);
        // acc = 230874 after tick, +20*309238 = 6415634; 34 more adds to wrap
        step(20, s, b);
        enable_i = 1'b0;
        step(5000, s, b);
        check("en_frozen_samples", s, 0);
        check("en_frozen_bits", b, 0);
        enable_i = 1'b1;
        wait_tick(200, e);
        check("en_resume_phase", e, 34);

        // ---- sel 111 -> 110 mid-period: new period ceil(2^24/154619)=109 ----
        step(10, s, b);
        baud_select_i = 3'd6;
        step(1, s, b);
        check("sel_busy", cfg_busy_o, 1);
        check("sel_busy_no_tick", sample_enable_o, 0);
        step(1, s, b);
        check("sel_busy_one_clk", cfg_busy_o, 0);
        wait_tick(200, e);
        check("sel_new_period", e, 108);

        // ---- RX resync: from half phase ceil(2^23/309238)=28 ----
        baud_select_i = 3'd7;
        step(1, s, b);
        check("rs_busy", cfg_busy_o, 1);
        step(10, s, b);
        resync_i = 1'b1;
        step(1, s, b);
        resync_i = 1'b0;
        check("rs_no_tick", sample_enable_o, 0);
        wait_tick(200, e);
        check("rs_first_sample", e, 28);
        pos = last_bit ? 1 : 0;
        for (int i = 2; i <= 16; i++) begin
            wait_tick(200, e);
            if (last_bit && pos == 0) pos = i;
        end
        check("rs_bit_at_sample", pos, 16);

        // ---- async reset mid-run while both ticks are high ----
        reset_ni = 1'b0;
        #1;
        check("arst_sample", sample_enable_o, 0);
        check("arst_bit", bit_tick_o, 0);
        check("arst_busy", cfg_busy_o, 0);
        @(negedge clk) reset_ni = 1'b1;
        wait_tick(200, e);
        check("arst_first_tick", e, 55);
        check("final_stray_bits", stray, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
